// File: rtl/sequential_multiplier_pkg.sv
// rtl/sequential_multiplier_pkg.sv - shared types and constants for the Booth multiplier
package sequential_multiplier_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width for an operand width w (must hold 0..w)
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Counter width for the default 32-bit operand width
    localparam int CNT_W = cnt_width(32);

    // Booth recode of the {Q[0], Q-1} pair; 00 and 11 leave ACC unchanged
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/sequential_multiplier_booth_step.sv
// rtl/sequential_multiplier_booth_step.sv - one combinational radix-2 Booth step
module sequential_multiplier_booth_step
    import sequential_multiplier_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W:0]   acc,
    input  logic [W:0]   m,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    output logic [W:0]   acc_next,
    output logic [W-1:0] q_next,
    output logic         q_m1_next
);

    logic [W:0] sum;

    // Add/subtract the multiplicand, then arithmetic-shift {ACC, Q, Q-1} right by one
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            BOOTH_ADD: sum = acc + m;
            BOOTH_SUB: sum = acc - m;
            default:   sum = acc;
        endcase
        acc_next  = {sum[W], sum[W:1]};
        q_next    = {sum[0], q[W-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - iterative signed WxW->2W Booth multiplier with start/done
module sequential_multiplier
    import sequential_multiplier_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           done
);

    localparam int CNT_BITS = cnt_width(W);

    state_t              state;
    state_t              next_state;
    logic                load;
    logic                last;

    logic [W:0]          acc;
    logic [W:0]          m;
    logic [W-1:0]        q;
    logic                q_m1;
    logic [CNT_BITS-1:0] count;

    logic [W:0]          acc_nx;
    logic [W-1:0]        q_nx;
    logic                q_m1_nx;

    sequential_multiplier_booth_step #(
        .W (W)
    ) u_booth_step (
        .acc       (acc),
        .m         (m),
        .q         (q),
        .q_m1      (q_m1),
        .acc_next  (acc_nx),
        .q_next    (q_nx),
        .q_m1_next (q_m1_nx)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only honoured outside BUSY
    always_comb begin
        next_state = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (count == CNT_BITS'(W - 1)) begin
                    last       = 1'b1;
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: load operands, run Booth steps, capture the result on the final step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            count   <= '0;
            product <= '0;
            done    <= 1'b0;
        end else if (load) begin
            acc     <= '0;
            m       <= {a[W-1], a};
            q       <= b;
            q_m1    <= 1'b0;
            count   <= '0;
            done    <= 1'b0;
        end else if (state == BUSY) begin
            acc     <= acc_nx;
            q       <= q_nx;
            q_m1    <= q_m1_nx;
            count   <= count + CNT_BITS'(1);
            if (last) begin
                product <= {acc_nx[W-1:0], q_nx};
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - scoreboard bench for sequential_multiplier
module tb_sequential_multiplier;

    localparam int W = 32;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] product;
    logic           done;

    int checks;
    int errors;

    logic [2*W-1:0] exp_q[$];
    logic           prev_done;

    sequential_multiplier #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%h required=0x%h", name, act, req);
        end
    endtask

    // Monitor: every rising edge of done pops one expected product
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: actual=0x%h required=none", product);
                end else begin
                    check("product", product, exp_q.pop_front());
                end
            end
            prev_done = done;
        end
    end

    // Launch one operation, check latency; optionally disturb start/a/b mid-BUSY and check hold
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [2*W-1:0] expv, input bit disturb);
        int n;
        @(negedge clk);
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (disturb && n == 4) begin
                start = 1'b1;
                a     = 32'd3;
                b     = 32'd3;
            end
            if (disturb && n == 5) begin
                start = 1'b0;
            end
        end while (!done && n < 200);
        check("latency", 64'(n), 64'(W));
        if (disturb) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check("hold_product", product, expv);
                check("hold_done", 64'(done), 64'd1);
            end
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        longint       sa;
        longint       sb;
        int           guard;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_product", product, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        do_op(32'd15, 32'd10, 64'd150, 1'b0);
        do_op(-32'sd25, 32'd12, 64'hFFFF_FFFF_FFFF_FED4, 1'b0);
        do_op(-32'sd8, -32'sd8, 64'd64, 1'b0);
        do_op(32'd0, 32'd123, 64'd0, 1'b0);
        do_op(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'd4611686014132420609, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 64'd4611686018427387904, 1'b0);
        do_op(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000, 1'b0);
        do_op(32'd10, 32'd11, 64'd110, 1'b1);

        // Asynchronous reset mid-operation
        @(negedge clk);
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("abort_product", product, 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        check("idle_after_abort_done", 64'(done), 64'd0);
        check("idle_after_abort_product", product, 64'd0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom();
            rb = $urandom();
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            do_op(ra, rb, 64'(sa * sb), 1'b0);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
